// File: rtl/bitbakery_serial_pkg.sv
// Constants and state encodings shared by the BitBakery serial link (tx and rx sides).
package bitbakery_serial_pkg;

  localparam logic [1:0] TAG_STATUS = 2'b00;
  localparam logic [1:0] TAG_JOGADA = 2'b01;
  localparam logic [1:0] TAG_PLAYER = 2'b10;
  localparam logic [1:0] TAG_MAP    = 2'b11;

  localparam int MAP_CHUNKS           = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Encodings double as the db_estado debug code.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  typedef enum logic {
    DEC_TAG     = 1'b0,
    DEC_PAYLOAD = 1'b1
  } dec_state_t;

endpackage

// File: rtl/bitbakery_serial_rx_uart.sv
// 8N1 byte receiver: 2-flop line synchronizer plus mid-bit sampling FSM.
module uart_rx_8n1
  import bitbakery_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] byte_data,
  output logic       byte_ok,
  output logic       byte_err,
  output logic [2:0] rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  logic [1:0]    fill;
  logic          armed;
  logic          rxd;
  rx_state_t     state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          done;

  assign rxd      = sync[1];
  assign rx_state = state;

  // A start edge only counts once a real high has passed the synchronizer,
  // so a line held low across reset cannot fake a byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync <= {sync[0], serial_in};
      fill <= {fill[0], 1'b1};
      if (fill[1] && rxd) armed <= 1'b1;
    end
  end

  always_comb begin
    nxt  = state;
    done = 1'b0;
    case (state)
      RX_IDLE:      if (armed && !rxd) nxt = RX_START;
      RX_START: begin
        done = (cnt == HALF_M1);
        if (done) nxt = rxd ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        done = (cnt == FULL_M1);
        if (done && bit_idx == 3'd7) nxt = RX_STOP;
      end
      RX_STOP: begin
        done = (cnt == FULL_M1);
        if (done) nxt = rxd ? RX_IDLE : RX_WAIT_IDLE;
      end
      RX_WAIT_IDLE: if (rxd) nxt = RX_IDLE;
      default:      nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      byte_data <= 8'h00;
      byte_ok   <= 1'b0;
      byte_err  <= 1'b0;
    end else begin
      state    <= nxt;
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
      cnt      <= (done || nxt != state) ? '0 : cnt + 1'b1;
      if (state == RX_START) bit_idx <= 3'd0;
      if (state == RX_DATA && done) begin
        shreg   <= {rxd, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == RX_STOP && done) begin
        byte_ok  <= rxd;
        byte_err <= !rxd;
        if (rxd) byte_data <= shreg;
      end
    end
  end

endmodule

// File: rtl/bitbakery_serial_rx.sv
// BitBakery telemetry receiver: tag decoder, obstacle-map shadow/mask and commit.
module bitbakery_serial_rx
  import bitbakery_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_in,
  output logic [1:0]  minigame,
  output logic [3:0]  estado,
  output logic [5:0]  jogada,
  output logic        dificuldade,
  output logic [3:0]  player_position,
  output logic [63:0] map_obstacles,
  output logic        status_valid,
  output logic        map_valid,
  output logic        frame_error,
  output logic        sync_error,
  output logic [2:0]  db_estado
);

  logic [7:0]            byte_data;
  logic                  byte_ok, byte_err;
  logic [2:0]            rx_state;
  dec_state_t            dec, dec_nxt;
  logic [2:0]            idx;
  logic [63:0]           shadow, shadow_nx;
  logic [MAP_CHUNKS-1:0] mask, mask_nx;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock     (clock),
    .reset     (reset),
    .serial_in (serial_in),
    .byte_data (byte_data),
    .byte_ok   (byte_ok),
    .byte_err  (byte_err),
    .rx_state  (rx_state)
  );

  always_comb begin
    dec_nxt = dec;
    if (byte_err) dec_nxt = DEC_TAG;
    else if (byte_ok) begin
      if (dec == DEC_PAYLOAD) dec_nxt = DEC_TAG;
      else if (byte_data[7:6] == TAG_MAP && byte_data[5:3] == 3'b000) dec_nxt = DEC_PAYLOAD;
    end
  end

  // Commit must see the chunk written by this very byte.
  always_comb begin
    shadow_nx = shadow;
    shadow_nx[{idx, 3'b000} +: 8] = byte_data;
    mask_nx = mask | (MAP_CHUNKS'(1) << idx);
  end

  always_comb begin
    db_estado = rx_state;
    if (rx_state == RX_IDLE && dec == DEC_PAYLOAD) db_estado = 3'd5;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec             <= DEC_TAG;
      idx             <= 3'd0;
      shadow          <= 64'h0;
      mask            <= '0;
      minigame        <= 2'b11;
      estado          <= 4'h0;
      jogada          <= 6'h00;
      dificuldade     <= 1'b0;
      player_position <= 4'h0;
      map_obstacles   <= 64'h0;
      status_valid    <= 1'b0;
      map_valid       <= 1'b0;
      frame_error     <= 1'b0;
      sync_error      <= 1'b0;
    end else begin
      dec          <= dec_nxt;
      status_valid <= 1'b0;
      map_valid    <= 1'b0;
      frame_error  <= 1'b0;
      sync_error   <= 1'b0;
      if (byte_err) begin
        frame_error <= 1'b1;
        if (dec == DEC_PAYLOAD) mask <= '0;
      end else if (byte_ok) begin
        if (dec == DEC_PAYLOAD) begin
          shadow <= shadow_nx;
          if (idx == 3'd7) begin
            mask <= '0;
            if (&mask_nx) begin
              map_obstacles <= shadow_nx;
              map_valid     <= 1'b1;
            end else begin
              sync_error <= 1'b1;
            end
          end else begin
            mask <= mask_nx;
          end
        end else begin
          case (byte_data[7:6])
            TAG_STATUS: begin
              minigame     <= byte_data[5:4];
              estado       <= byte_data[3:0];
              status_valid <= 1'b1;
            end
            TAG_JOGADA: begin
              jogada       <= byte_data[5:0];
              status_valid <= 1'b1;
            end
            TAG_PLAYER: begin
              dificuldade     <= byte_data[4];
              player_position <= byte_data[3:0];
              status_valid    <= 1'b1;
            end
            default: begin
              if (byte_data[5:3] != 3'b000) sync_error <= 1'b1;
              else                          idx        <= byte_data[2:0];
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bitbakery_serial_rx.sv
// Directed bench for bitbakery_serial_rx at 8 clocks per bit.
module tb_bitbakery_serial_rx;

  localparam int CPB = 8;
  localparam int GAP = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b1;
  logic [1:0]  minigame;
  logic [3:0]  estado;
  logic [5:0]  jogada;
  logic        dificuldade;
  logic [3:0]  player_position;
  logic [63:0] map_obstacles;
  logic        status_valid, map_valid, frame_error, sync_error;
  logic [2:0]  db_estado;

  int tests = 0;
  int fails = 0;
  int n_sv = 0, n_mv = 0, n_fe = 0, n_se = 0, n_excl = 0;

  always #5 clock = ~clock;

  bitbakery_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock           (clock),
    .reset           (reset),
    .serial_in       (serial_in),
    .minigame        (minigame),
    .estado          (estado),
    .jogada          (jogada),
    .dificuldade     (dificuldade),
    .player_position (player_position),
    .map_obstacles   (map_obstacles),
    .status_valid    (status_valid),
    .map_valid       (map_valid),
    .frame_error     (frame_error),
    .sync_error      (sync_error),
    .db_estado       (db_estado)
  );

  always @(negedge clock) begin
    if (status_valid) n_sv++;
    if (map_valid)    n_mv++;
    if (frame_error)  n_fe++;
    if (sync_error)   n_se++;
    if ((map_valid && sync_error) || (map_valid && status_valid)) n_excl++;
  end

  typedef struct {
    logic [7:0] b;
    logic [1:0] mg;
    logic [3:0] est;
    logic [5:0] jog;
    logic       dif;
    logic [3:0] pos;
  } vec_t;

  vec_t vecs[6];

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      cyc(CPB);
    end
    serial_in = stop_bit;
    cyc(CPB);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
    serial_in = 1'b1;
    cyc(GAP);
  endtask

  int sv0, mv0, fe0, se0;
  task automatic snap();
    sv0 = n_sv; mv0 = n_mv; fe0 = n_fe; se0 = n_se;
  endtask

  initial begin
    vecs[0] = '{8'h1A, 2'b01, 4'hA, 6'h00, 1'b0, 4'h0};
    vecs[1] = '{8'h65, 2'b01, 4'hA, 6'h25, 1'b0, 4'h0};
    vecs[2] = '{8'h9C, 2'b01, 4'hA, 6'h25, 1'b1, 4'hC};
    vecs[3] = '{8'hA3, 2'b01, 4'hA, 6'h25, 1'b0, 4'h3};
    vecs[4] = '{8'h7F, 2'b01, 4'hA, 6'h3F, 1'b0, 4'h3};
    vecs[5] = '{8'h2E, 2'b10, 4'hE, 6'h3F, 1'b0, 4'h3};

    cyc(4);
    reset = 1'b0;
    cyc(4);
    check("reset_status", {minigame, estado, jogada, dificuldade, player_position},
          {2'b11, 4'h0, 6'h00, 1'b0, 4'h0});
    check("reset_map", map_obstacles, 64'h0);
    check("reset_db", db_estado, 3'd0);
    check("reset_pulses", n_sv + n_mv + n_fe + n_se, 0);

    // status bytes
    for (int v = 0; v < 6; v++) begin
      snap();
      send(vecs[v].b);
      check($sformatf("status_vec%0d", v),
            {minigame, estado, jogada, dificuldade, player_position},
            {vecs[v].mg, vecs[v].est, vecs[v].jog, vecs[v].dif, vecs[v].pos});
      check($sformatf("status_pulse%0d", v), n_sv - sv0, 1);
    end

    // full map
    snap();
    for (int i = 0; i < 8; i++) begin
      send(8'hC0 | 8'(i));
      if (i == 3) check("db_expect_payload", db_estado, 3'd5);
      send(8'(8'h11 * (i + 1)));
    end
    check("full_map", map_obstacles, 64'h8877665544332211);
    check("full_map_valid", n_mv - mv0, 1);
    check("full_map_noerr", n_se - se0, 0);
    check("full_map_nostatus", n_sv - sv0, 0);

    // incomplete map
    snap();
    send(8'hC5); send(8'hAA);
    send(8'hC7); send(8'hFF);
    check("incomplete_sync", n_se - se0, 1);
    check("incomplete_map", map_obstacles, 64'h8877665544332211);
    check("incomplete_novalid", n_mv - mv0, 0);

    // malformed header
    snap();
    send(8'hE8);
    check("bad_header_sync", n_se - se0, 1);
    check("bad_header_db", db_estado, 3'd0);

    // frame error inside a payload aborts and clears the mask
    snap();
    for (int i = 0; i < 7; i++) begin
      send(8'hC0 | 8'(i));
      send(8'h5A);
    end
    send(8'hC7);
    send_byte(8'h55, 1'b0);
    serial_in = 1'b1;
    cyc(GAP);
    check("abort_frame_err", n_fe - fe0, 1);
    check("abort_db_tag", db_estado, 3'd0);
    send(8'hC7); send(8'h99);
    check("abort_mask_cleared", n_se - se0, 1);
    check("abort_map_kept", map_obstacles, 64'h8877665544332211);

    // framing error with line held low
    snap();
    send_byte(8'h3F, 1'b0);
    serial_in = 1'b0;
    cyc(20);
    serial_in = 1'b1;
    cyc(GAP);
    check("frame_err_pulse", n_fe - fe0, 1);
    check("frame_err_dropped", n_sv - sv0, 0);
    send(8'h3F);
    check("frame_err_next", {minigame, estado}, {2'b11, 4'hF});
    check("frame_err_status", n_sv - sv0, 1);

    // start glitch
    snap();
    serial_in = 1'b0;
    cyc(2);
    serial_in = 1'b1;
    cyc(40);
    check("glitch_quiet", (n_sv - sv0) + (n_mv - mv0) + (n_fe - fe0) + (n_se - se0), 0);
    check("glitch_db", db_estado, 3'd0);

    // reset in the middle of a map
    send(8'hC0); send(8'hFF);
    serial_in = 1'b0; cyc(CPB);
    serial_in = 1'b1; cyc(CPB);
    serial_in = 1'b0; cyc(3);
    reset = 1'b1;
    cyc(3);
    check("rst_mid_status", {minigame, estado, jogada, dificuldade, player_position},
          {2'b11, 4'h0, 6'h00, 1'b0, 4'h0});
    check("rst_mid_map", map_obstacles, 64'h0);
    check("rst_mid_db", db_estado, 3'd0);
    check("rst_mid_pulses", {status_valid, map_valid, frame_error, sync_error}, 4'b0000);
    snap();
    reset = 1'b0;
    cyc(20);
    serial_in = 1'b1;
    cyc(CPB * 12);
    check("rst_low_line_ignored", (n_sv - sv0) + (n_mv - mv0) + (n_fe - fe0) + (n_se - se0), 0);
    for (int i = 0; i < 8; i++) begin
      send(8'hC0 | 8'(i));
      send(8'(8'h11 * (i + 1)));
    end
    check("rst_then_map", map_obstacles, 64'h8877665544332211);
    check("rst_then_map_valid", n_mv - mv0, 1);

    check("pulse_exclusive", n_excl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
